// File: rtl/mem_dsram_ctrl.sv
// MEM-stage data-SRAM controller: issues one req/addr_ok/data_ok access per M-stage load/store,
// stalls M until it completes, flags AdEL/AdES and extends the load result for MEM/WB.
module mem_dsram_ctrl #(
    parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        m_valid,
    input  logic        m_load,
    input  logic        m_store,
    input  logic [2:0]  m_ltype,
    input  logic [1:0]  m_stype,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_allowout,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        stall_m,
    output logic [31:0] load_data,
    output logic        adel,
    output logic        ades
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        discard, discard_nxt;
    logic [2:0]  ltype_q;
    logic [1:0]  off_q;
    logic        access;
    logic [1:0]  size_c;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_c;

    always_comb begin
        adel = 1'b0;
        ades = 1'b0;
        if (m_valid && m_load) begin
            case (m_ltype)
                3'd0:       adel = |m_addr[1:0];
                3'd1, 3'd2: adel = m_addr[0];
                default:    adel = 1'b0;
            endcase
        end
        if (m_valid && m_store) begin
            case (m_stype)
                2'd0:    ades = |m_addr[1:0];
                2'd1:    ades = m_addr[0];
                default: ades = 1'b0;
            endcase
        end
    end

    assign access = m_valid && (m_load || m_store) && !adel && !ades && !flush;

    // Request fields decoded from the M-stage instruction; captured only when leaving IDLE.
    always_comb begin
        size_c  = 2'd2;
        wstrb_c = 4'b0000;
        wdata_c = m_wdata;
        if (m_store) begin
            case (m_stype)
                2'd1: begin
                    size_c  = 2'd1;
                    wstrb_c = 4'b0011 << m_addr[1:0];
                    wdata_c = {2{m_wdata[15:0]}};
                end
                2'd2: begin
                    size_c  = 2'd0;
                    wstrb_c = 4'b0001 << m_addr[1:0];
                    wdata_c = {4{m_wdata[7:0]}};
                end
                default: wstrb_c = 4'b1111;
            endcase
        end else begin
            case (m_ltype)
                3'd1, 3'd2: size_c = 2'd1;
                3'd3, 3'd4: size_c = 2'd0;
                default:    size_c = 2'd2;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = data_sram_rdata[7:0];
            2'd1:    byte_sel = data_sram_rdata[15:8];
            2'd2:    byte_sel = data_sram_rdata[23:16];
            default: byte_sel = data_sram_rdata[31:24];
        endcase
        half_sel = off_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (ltype_q)
            3'd1:    ext_c = {{16{half_sel[15]}}, half_sel};
            3'd2:    ext_c = {16'd0, half_sel};
            3'd3:    ext_c = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    ext_c = {24'd0, byte_sel};
            default: ext_c = data_sram_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        stall_m     = 1'b0;
        case (state)
            IDLE: begin
                stall_m = access;
                if (access) state_nxt = REQ;
            end
            REQ: begin
                stall_m = 1'b1;
                if (flush) discard_nxt = 1'b1;
                if (data_sram_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                stall_m = 1'b1;
                if (data_sram_data_ok) begin
                    discard_nxt = 1'b0;
                    state_nxt   = (discard || flush) ? IDLE : DONE;
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            DONE: begin
                if (m_allowout || flush) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sram_req   <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_addr  <= 32'd0;
            data_sram_wstrb <= 4'd0;
            data_sram_wdata <= 32'd0;
            ltype_q         <= 3'd0;
            off_q           <= 2'd0;
            load_data       <= 32'd0;
        end else begin
            if (state == IDLE && access) begin
                data_sram_req   <= 1'b1;
                data_sram_wr    <= m_store;
                data_sram_size  <= size_c;
                data_sram_addr  <= m_addr & PHYS_MASK;
                data_sram_wstrb <= wstrb_c;
                data_sram_wdata <= wdata_c;
                ltype_q         <= m_ltype;
                off_q           <= m_addr[1:0];
            end else if (state == REQ && data_sram_addr_ok) begin
                data_sram_req <= 1'b0;
            end
            // A flushed transaction drains without touching the result register.
            if (state == WAIT && data_sram_data_ok && !discard && !flush)
                load_data <= data_sram_wr ? 32'd0 : ext_c;
        end
    end
endmodule
